mult_seq_ctrl: RTL and testbench

Sequential shift-and-add multiplier controller for the calculator datapath. It drives the existing combinational `full_adder_nbits` over `width` clock cycles to produce a `2*width`-bit unsigned product. It turns one shared adder into a multi-cycle multiply unit with a start/ready/done handshake. It sits between the calculator's operation decoder and the result register.

---
 rtl/calc_defs.sv | 12 +
 rtl/mult_seq_ctrl_if.sv | 16 +
 rtl/full_adder_nbits.sv | 11 +
 rtl/mult_seq_ctrl.sv | 78 +++++++
 tb/tb_mult_seq_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_defs.sv
// rtl/calc_defs.sv - shared calculator definitions: state encodings and default operand width
package calc_defs;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - start/ready/done handshake and operand/product bus of the multiplier
interface mult_seq_ctrl_if
   import calc_defs::*;
#(
   parameter int width = DEF_WIDTH
);
   logic                 start_i;
   logic [width-1:0]     a_i;
   logic [width-1:0]     b_i;
   logic                 ready_o;
   logic                 done_o;
   logic [2*width-1:0]   p_o;

   modport master (output start_i, a_i, b_i, input ready_o, done_o, p_o);
   modport slave  (input start_i, a_i, b_i, output ready_o, done_o, p_o);
endinterface

// File: rtl/full_adder_nbits.sv
// rtl/full_adder_nbits.sv - combinational unsigned n-bit adder with carry-out
module full_adder_nbits #(
   parameter int width = 8
) (
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic [width-1:0] s_o,
   output logic             cout_o
);
   assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - shift-and-add multiplier sequencing one shared adder over width cycles
module mult_seq_ctrl
   import calc_defs::*;
#(
   parameter int width = DEF_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   mult_seq_ctrl_if.slave   bus
);
   localparam int CW = $clog2(width) + 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   state_t               state, state_next;
   logic [width-1:0]     m;
   logic [2*width-1:0]   acc;
   logic [2*width-1:0]   acc_next;
   logic [CW-1:0]        cnt;
   logic [2*width-1:0]   p;
   logic [width-1:0]     add_b;
   logic [width-1:0]     sum;
   logic                 cout;

   // Add the multiplicand only when the current multiplier bit is set.
   assign add_b = acc[0] ? m : '0;

   full_adder_nbits #(.width(width)) u_adder (
      .a_i    (acc[2*width-1:width]),
      .b_i    (add_b),
      .s_o    (sum),
      .cout_o (cout)
   );

   // Carry becomes the new MSB so the product never loses a bit.
   assign acc_next = {cout, sum, acc[width-1:1]};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start_i) state_next = RUN;
         RUN:     if (cnt == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m   <= '0;
         acc <= '0;
         cnt <= '0;
         p   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start_i) begin
               m   <= bus.a_i;
               acc <= {{width{1'b0}}, bus.b_i};
               cnt <= '0;
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) p <= acc_next;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready_o = (state == IDLE);
   assign bus.done_o  = (state == DONE);
   assign bus.p_o     = p;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - self-checking bench for mult_seq_ctrl at width 8 and 16
module tb_mult_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   mult_seq_ctrl_if #(.width(8))  b8 ();
   mult_seq_ctrl_if #(.width(16)) b16 ();

   mult_seq_ctrl #(.width(8))  dut8  (.clk_i(clk), .rst_n_i(rst_n), .bus(b8));
   mult_seq_ctrl #(.width(16)) dut16 (.clk_i(clk), .rst_n_i(rst_n), .bus(b16));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   // Issue one width-8 multiply and wait for done; lat = cycles from accept to done.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output logic [15:0] p);
      b8.start_i = 1'b1;
      b8.a_i = a;
      b8.b_i = b;
      step();
      b8.start_i = 1'b0;
      b8.a_i = 8'($urandom);
      b8.b_i = 8'($urandom);
      lat = -1;
      p = '0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (b8.done_o) begin
            lat = k;
            p = b8.p_o;
            break;
         end
      end
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [31:0] p);
      b16.start_i = 1'b1;
      b16.a_i = a;
      b16.b_i = b;
      step();
      b16.start_i = 1'b0;
      b16.a_i = 16'($urandom);
      b16.b_i = 16'($urandom);
      lat = -1;
      p = '0;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (b16.done_o) begin
            lat = k;
            p = b16.p_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("reset_ready", 32'(b8.ready_o), 32'd1);
      chk("reset_done",  32'(b8.done_o),  32'd0);
      chk("reset_p",     32'(b8.p_o),     32'h0000);
      chk("reset_ready16", 32'(b16.ready_o), 32'd1);
   endtask

   task automatic test_max();
      int lat;
      logic [15:0] p;
      op8(8'hFF, 8'hFF, lat, p);
      chk("max_latency", 32'(lat), 32'd8);
      chk("max_product", 32'(p), 32'hFE01);
      step();
      chk("max_done_pulse", 32'(b8.done_o), 32'd0);
      chk("max_ready_back", 32'(b8.ready_o), 32'd1);
   endtask

   task automatic test_zero();
      int lat;
      logic [15:0] p;
      op8(8'h00, 8'hA5, lat, p);
      chk("zero_latency", 32'(lat), 32'd8);
      chk("zero_product", 32'(p), 32'h0000);
      step();
      op8(8'h5A, 8'h00, lat, p);
      chk("zero_b_latency", 32'(lat), 32'd8);
      chk("zero_b_product", 32'(p), 32'h0000);
      step();
   endtask

   task automatic test_start_busy();
      int dones = 0;
      int first = -1;
      logic [15:0] p = '0;
      b8.start_i = 1'b1;
      b8.a_i = 8'd12;
      b8.b_i = 8'd11;
      step();
      b8.start_i = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         b8.start_i = (k == 4);
         if (k == 4) begin
            b8.a_i = 8'd3;
            b8.b_i = 8'd3;
         end
         step();
         if (k == 1) chk("busy_ready_low", 32'(b8.ready_o), 32'd0);
         if (b8.done_o) begin
            dones++;
            if (first < 0) begin
               first = k;
               p = b8.p_o;
            end
         end
      end
      b8.start_i = 1'b0;
      chk("busy_done_count", 32'(dones), 32'd1);
      chk("busy_latency", 32'(first), 32'd8);
      chk("busy_product", 32'(p), 32'd132);
   endtask

   task automatic test_reset_mid();
      int lat;
      int dones = 0;
      logic [15:0] p;
      b8.start_i = 1'b1;
      b8.a_i = 8'd200;
      b8.b_i = 8'd2;
      step();
      b8.start_i = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(b8.ready_o), 32'd1);
      chk("midrst_done",  32'(b8.done_o),  32'd0);
      chk("midrst_p",     32'(b8.p_o),     32'd0);
      for (int k = 0; k < 8; k++) begin
         step();
         if (b8.done_o) dones++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (b8.done_o) dones++;
      end
      chk("midrst_no_done", 32'(dones), 32'd0);
      op8(8'd7, 8'd6, lat, p);
      chk("midrst_after_product", 32'(p), 32'd42);
      chk("midrst_after_latency", 32'(lat), 32'd8);
      step();
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [7:0]  a, b;
      logic [15:0] p;
      for (int i = 0; i < 100; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         chk("b2b_ready", 32'(b8.ready_o), 32'd1);
         op8(a, b, lat, p);
         chk("b2b_latency", 32'(lat), 32'd8);
         chk("b2b_product", 32'(p), 32'(16'(a) * 16'(b)));
         step();
         chk("b2b_done_pulse", 32'(b8.done_o), 32'd0);
      end
   endtask

   task automatic test_wide();
      int lat;
      logic [15:0] a, b;
      logic [31:0] p;
      logic [15:0] edge_a [3] = '{16'hFFFF, 16'h0000, 16'h8001};
      logic [15:0] edge_b [3] = '{16'hFFFF, 16'h1234, 16'hFFFF};
      for (int i = 0; i < 53; i++) begin
         if (i < 3) begin
            a = edge_a[i];
            b = edge_b[i];
         end else begin
            a = 16'($urandom);
            b = 16'($urandom);
         end
         op16(a, b, lat, p);
         chk("wide_latency", 32'(lat), 32'd16);
         chk("wide_product", p, 32'(a) * 32'(b));
         step();
         chk("wide_done_pulse", 32'(b16.done_o), 32'd0);
         chk("wide_ready_back", 32'(b16.ready_o), 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      b8.start_i = 1'b0;
      b8.a_i = '0;
      b8.b_i = '0;
      b16.start_i = 1'b0;
      b16.a_i = '0;
      b16.b_i = '0;
      test_reset();
      test_max();
      test_zero();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      test_wide();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
